// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, one parity bit,
// then SB_TICK ticks of stop, all paced by a shared 16x baud tick.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PAR_TYP   = 0,   // 0 = even, 1 = odd
  parameter int unsigned SB_TICK   = 16   // 16 = 1 stop bit, 32 = 2 stop bits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Tick counter is 4 bits for the usual 16-tick stop; widened only when a
  // longer stop period needs more range.
  localparam int unsigned TCW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TCW-1:0] BIT_LAST  = TCW'(15);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(SB_TICK - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic           PAR_ODD   = (PAR_TYP != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;

  // Handshake flags follow the state directly so a waiting word is taken in
  // the first IDLE cycle.
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx       = tx_q;
  assign tx_done  = done_q;

  // State and datapath registers; reset returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; tx_d is the value the line takes on the following edge.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ PAR_ODD;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            tx_d       = shift_q[0];
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              tx_d      = par_q;
              state_d   = PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
              tx_d      = shift_d[0];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            tx_d       = 1'b1;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule
